mult_arbiter: RTL and testbench

Shares one sequential signed multiplier (radix-4 Booth core with `clk`/`rst`/`en`/`load`/`A`/`B`/`OUT` ports) between NREQ requesters. The block arbitrates requests round-robin, sequences the core's load and run phases, waits the fixed compute latency, then returns the 2*WIDTH-bit product with the winner's ID. It sits between the requesters and the multiplier core and owns every control input of the core.

---
 rtl/mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_mult_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential signed multiplier core between NREQ
// requesters. A round-robin arbiter picks one request. The block then loads
// the core, waits out its fixed latency and returns the product. The product
// is tagged with the ID of the requester that owns it.
module mult_arbiter #(
    parameter int WIDTH       = 32,
    parameter int NREQ        = 4,
    parameter int MULT_CYCLES = 17,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_data,
    output logic                    busy,
    output logic                    mult_en,
    output logic                    mult_load,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic [2*WIDTH-1:0]      mult_out
);

    localparam int CW = $clog2(MULT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDW-1:0]          rr_ptr;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        op_a;
    logic [WIDTH-1:0]        op_b;
    logic [IDW-1:0]          cur_id;

    logic [NREQ-1:0]         grant;
    logic [IDW-1:0]          grant_id;
    logic                    grant_found;
    logic [IDW-1:0]          ptr_next;
    logic                    accept;
    int                      scan_idx;

    // Round-robin scan: first valid requester at or above rr_ptr, with wrap.
    // Grants are offered only while IDLE, so nothing is accepted mid-operation.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        if (state == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = (int'(rr_ptr) + k) % NREQ;
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found        = 1'b1;
                    grant[scan_idx]    = 1'b1;
                    grant_id           = IDW'(scan_idx);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = grant_found;
    assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and core control decode.
    always_comb begin
        state_next = state;
        mult_en    = 1'b0;
        mult_load  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                mult_en    = 1'b1;
                mult_load  = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                mult_en = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, round-robin pointer, latency counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cur_id    <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[int'(grant_id) * WIDTH +: WIDTH];
                op_b   <= req_b[int'(grant_id) * WIDTH +: WIDTH];
                cur_id <= grant_id;
                rr_ptr <= ptr_next;
            end
            if (state == LOAD) begin
                cnt <= CW'(MULT_CYCLES - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == BUSY && cnt == '0) begin
                resp_data <= mult_out;
                resp_id   <= cur_id;
            end
        end
    end

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign mult_a     = op_a;
    assign mult_b     = op_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter. A behavioural multiplier core model sits behind
// the arbiter. The core drives a poison value until its latency has elapsed.
// Expected products are queued when requests are issued. They are compared
// against each response handshake.
module tb_mult_arbiter;

    localparam int WIDTH       = 32;
    localparam int NREQ        = 4;
    localparam int MULT_CYCLES = 17;
    localparam int IDW         = $clog2(NREQ);

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [IDW-1:0]          resp_id;
    logic [2*WIDTH-1:0]      resp_data;
    logic                    busy;
    logic                    mult_en;
    logic                    mult_load;
    logic [WIDTH-1:0]        mult_a;
    logic [WIDTH-1:0]        mult_b;
    logic [2*WIDTH-1:0]      mult_out;

    mult_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .MULT_CYCLES(MULT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy),
        .mult_en(mult_en), .mult_load(mult_load),
        .mult_a(mult_a), .mult_b(mult_b),
        .mult_out(mult_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: captures operands on load; the product appears once
    // MULT_CYCLES-1 run cycles have followed the load edge.
    logic signed [WIDTH-1:0] core_a;
    logic signed [WIDTH-1:0] core_b;
    int                      core_cnt;
    initial begin
        core_a   = '0;
        core_b   = '0;
        core_cnt = 0;
        mult_out = 64'hDEADBEEF_CAFEF00D;
    end
    always @(posedge clk) begin
        if (mult_en && mult_load) begin
            core_a   <= mult_a;
            core_b   <= mult_b;
            core_cnt <= 0;
            mult_out <= 64'hDEADBEEF_CAFEF00D;
        end else if (mult_en) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt + 1 == MULT_CYCLES - 1)
                mult_out <= $signed(64'(core_a)) * $signed(64'(core_b));
        end
    end

    typedef struct {
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   grant_q[$];
    int   acc_q[$];
    int   cyc;
    int   acc_cyc;
    int   valid_cyc;
    int   en_cnt;
    int   ld_cnt;
    logic rv_prev;
    int   n_checks;
    int   n_fail;

    // Advance one clock: observe accepts and response handshakes before the
    // edge, then retire accepted requests just after it.
    task automatic tick();
        logic [NREQ-1:0] acc;
        exp_t            e;
        @(negedge clk);
        acc = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                grant_q.push_back(i);
                acc_q.push_back(cyc);
                acc_cyc = cyc;
            end
        end
        if (resp_valid && !rv_prev) valid_cyc = cyc;
        rv_prev = resp_valid;
        if (mult_en) en_cnt++;
        if (mult_load) ld_cnt++;
        if (resp_valid && resp_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, required no response", resp_id, resp_data);
            end else begin
                e = sb_q.pop_front();
                if (resp_id !== e.id || resp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_resp: got id=%0d data=%h, required id=%0d data=%h",
                             resp_id, resp_data, e.id, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        cyc++;
    endtask

    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] p);
        exp_t e;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
        e.id   = i[IDW-1:0];
        e.data = p;
        sb_q.push_back(e);
    endtask

    task automatic run_until_done();
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && req_valid == '0 && !busy) && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL timeout: got %0d responses outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        sb_q.delete();
        grant_q.delete();
        acc_q.delete();
        rv_prev    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        #7;
        n_checks++;
        if ({busy, resp_valid, mult_en, mult_load} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/rv/en/ld=%b, required 0000", {busy, resp_valid, mult_en, mult_load});
        end
        n_checks++;
        if (resp_data !== '0 || resp_id !== '0 || mult_a !== '0 || mult_b !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h id=%0d a=%h b=%h, required all 0", resp_data, resp_id, mult_a, mult_b);
        end
        do_reset();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %b, required 0000", req_ready);
        end
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_ready_comb: got %b, required 0100", req_ready);
        end
        req_valid = 4'b1010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_ready_scan: got %b, required 0010", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        issue(0, 32'h00087234, 32'h00000348, 64'h00000000_1BB6BAA0);
        run_until_done();
        n_checks++;
        if (valid_cyc - acc_cyc != MULT_CYCLES + 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d, required %0d", valid_cyc - acc_cyc, MULT_CYCLES + 2);
        end
        n_checks++;
        if (grant_q.size() != 1 || grant_q[0] != 0) begin
            n_fail++;
            $display("FAIL single_grant: got %0d grants, required 1 grant to 0", grant_q.size());
        end
    endtask

    task automatic test_all_four();
        int exp_order[4];
        exp_order = '{0, 1, 2, 3};
        do_reset();
        issue(0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F);
        issue(1, 32'hFFFFFFFE, 32'h00000007, 64'hFFFFFFFF_FFFFFFF2);
        issue(2, 32'hFFFFFEFD, 32'hFFFFFEFD, 64'h00000000_00010609);
        issue(3, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
        run_until_done();
        n_checks++;
        if (grant_q.size() != 4) begin
            n_fail++;
            $display("FAIL all4_count: got %0d grants, required 4", grant_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (grant_q[k] != exp_order[k]) begin
                    n_fail++;
                    $display("FAIL all4_order[%0d]: got %0d, required %0d", k, grant_q[k], exp_order[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (acc_q[k+1] - acc_q[k] != MULT_CYCLES + 3) begin
                    n_fail++;
                    $display("FAIL all4_spacing[%0d]: got %0d, required %0d", k, acc_q[k+1] - acc_q[k], MULT_CYCLES + 3);
                end
            end
        end
    endtask

    task automatic test_signed_wrap();
        int exp_order[4];
        exp_order = '{3, 1, 2, 0};
        do_reset();
        issue(3, 32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFF_F7747564);
        run_until_done();
        issue(1, 32'h00000000, 32'hB887CAAF, 64'h00000000_00000000);
        run_until_done();
        issue(2, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        issue(0, 32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000);
        run_until_done();
        n_checks++;
        if (grant_q.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d grants, required 4", grant_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (grant_q[k] != exp_order[k]) begin
                    n_fail++;
                    $display("FAIL wrap_order[%0d]: got %0d, required %0d", k, grant_q[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int hs_cyc;
        do_reset();
        resp_ready = 1'b0;
        issue(0, 32'h00087234, 32'h00000348, 64'h00000000_1BB6BAA0);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (!resp_valid) begin
            n_fail++;
            $display("FAIL bp_wait: got resp_valid=0, required 1");
        end
        issue(1, 32'h00000011, 32'h00000011, 64'h00000000_00000121);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== 64'h00000000_1BB6BAA0 || resp_id !== '0
                || busy !== 1'b1 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rv=%b data=%h id=%0d busy=%b ready=%b, required 1 1bb6baa0 0 1 0000",
                         k, resp_valid, resp_data, resp_id, busy, req_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        hs_cyc = cyc - 1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_ready_after: got %b, required 0010", req_ready);
        end
        tick();
        n_checks++;
        if (acc_cyc != hs_cyc + 1) begin
            n_fail++;
            $display("FAIL bp_accept_cycle: got %0d, required %0d", acc_cyc, hs_cyc + 1);
        end
        run_until_done();
    endtask

    task automatic test_rst_mid();
        int n;
        logic seen;
        do_reset();
        issue(1, 32'h00012345, 32'h00000010, 64'h00000000_00123450);
        n = 0;
        while (grant_q.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        while (cyc < acc_cyc + 13) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || mult_en !== 1'b0 || resp_valid !== 1'b0 || mult_a !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got busy=%b en=%b rv=%b a=%h, required 0 0 0 0", busy, mult_en, resp_valid, mult_a);
        end
        sb_q.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            seen = seen | resp_valid | busy;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got activity=%b, required 0", seen);
        end
        issue(1, 32'h00012345, 32'h00000010, 64'h00000000_00123450);
        run_until_done();
    endtask

    task automatic test_core_control();
        do_reset();
        en_cnt = 0;
        ld_cnt = 0;
        issue(2, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF);
        run_until_done();
        n_checks++;
        if (ld_cnt != 1) begin
            n_fail++;
            $display("FAIL core_load_cycles: got %0d, required 1", ld_cnt);
        end
        n_checks++;
        if (en_cnt != MULT_CYCLES + 1) begin
            n_fail++;
            $display("FAIL core_en_cycles: got %0d, required %0d", en_cnt, MULT_CYCLES + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        acc_cyc    = 0;
        valid_cyc  = 0;
        en_cnt     = 0;
        ld_cnt     = 0;
        rv_prev    = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_valid  = '0;
        resp_ready = 1'b1;
        rst        = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_signed_wrap();
        test_backpressure();
        test_rst_mid();
        test_core_control();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
